// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch sequencer.
//   fetch_state_e    : sequencer FSM states (IDLE, REQ, KILL, HOLD)
//   pc_sel_e         : next-pc selection driven by the FSM into fetch_pc_reg
//   DATA_W           : address / instruction width
//   INSN_BYTES       : byte stride between sequential instructions
//   DEF_RESET_VECTOR : default first fetch address after reset
//   DEF_TRAP_VECTOR  : default trap redirect target
package fetch_pkg;

  localparam int DATA_W     = 32;
  localparam int INSN_BYTES = 4;

  localparam logic [DATA_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [DATA_W-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_KILL = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_TGT  = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter register with its next-pc mux and +4 adder.
// Ports:
//   i_clk     in   clock, rising edge
//   i_rst_n   in   asynchronous active-low reset (pc <= RESET_VECTOR)
//   sel       in   next-pc select: hold / pc+4 / target
//   target    in   redirect target, already word aligned by the caller
//   pc        out  current fetch address
//   pc_inc    out  pc + INSN_BYTES, wrapping modulo 2^32
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  pc_sel_e           sel,
  input  logic [DATA_W-1:0] target,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_inc
);

  logic [DATA_W-1:0] pc_nx;

  // Carry out of bit 31 is dropped, so 0xFFFF_FFFC + 4 wraps to 0.
  assign pc_inc = pc + DATA_W'(INSN_BYTES);

  always_comb begin
    pc_nx = pc;
    case (sel)
      PC_INC:  pc_nx = pc_inc;
      PC_TGT:  pc_nx = target;
      default: pc_nx = pc;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pc <= RESET_VECTOR;
    else          pc <= pc_nx;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch sequencer with redirect, kill and stall.
// Optional feature: define FETCH_TRAP_EN to add i_trap, a top-priority
// redirect to TRAP_VECTOR.
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_stall          decode hazard; freezes the delivered instruction
//   i_br_sel         branch redirect request, target i_pc_bru (bits [1:0] ignored)
//   i_trap           trap redirect (FETCH_TRAP_EN builds only)
//   o_imem_req       instruction memory request, held until i_imem_ack
//   o_imem_addr      word-aligned request address
//   i_imem_ack       one-cycle acknowledge, i_imem_rdata valid with it
//   i_imem_rdata     fetched instruction
//   o_if_valid       registered fetch result valid
//   o_if_instr       fetched instruction
//   o_if_pc          address of o_if_instr
//   o_pc_four        o_if_pc + 4
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [DATA_W-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_br_sel,
  input  logic [DATA_W-1:0] i_pc_bru,
`ifdef FETCH_TRAP_EN
  input  logic              i_trap,
`endif
  output logic              o_imem_req,
  output logic [DATA_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_instr,
  output logic [DATA_W-1:0] o_if_pc,
  output logic [DATA_W-1:0] o_pc_four
);

  fetch_state_e      state_q, state_nx;
  pc_sel_e           pc_sel;
  logic [DATA_W-1:0] pc, pc_inc, pc_tgt;
  logic [DATA_W-1:0] kill_tgt_q;
  logic              kill_ld;
  logic              cap;
  logic              vld_nx;
  logic              trap;
  logic              redir;
  logic [DATA_W-1:0] redir_tgt;
  logic              vld_p1;
  logic [DATA_W-1:0] instr_p1, pc_p1, pc_four_p1;
  logic [1:0]        bru_lsb_unused;

`ifdef FETCH_TRAP_EN
  assign trap = i_trap;
`else
  assign trap = 1'b0;
`endif

  assign bru_lsb_unused = i_pc_bru[1:0];

  // Trap outranks a branch redirect presented in the same cycle.
  assign redir     = trap | i_br_sel;
  assign redir_tgt = trap ? TRAP_VECTOR : {i_pc_bru[DATA_W-1:2], 2'b00};

  fetch_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .sel     (pc_sel),
    .target  (pc_tgt),
    .pc      (pc),
    .pc_inc  (pc_inc)
  );

  // pc only moves when a request completes or is abandoned, so the
  // outstanding address stays stable through REQ and KILL.
  assign o_imem_req  = (state_q == ST_REQ) || (state_q == ST_KILL);
  assign o_imem_addr = pc;

  always_comb begin
    state_nx = state_q;
    pc_sel   = PC_HOLD;
    pc_tgt   = redir_tgt;
    kill_ld  = 1'b0;
    cap      = 1'b0;
    vld_nx   = vld_p1;
    case (state_q)
      ST_IDLE: begin
        vld_nx   = 1'b0;
        state_nx = ST_REQ;
        if (redir) pc_sel = PC_TGT;
      end
      ST_REQ: begin
        if (redir) begin
          vld_nx = 1'b0;
          if (i_imem_ack) begin
            pc_sel = PC_TGT;
          end else begin
            kill_ld  = 1'b1;
            state_nx = ST_KILL;
          end
        end else if (i_imem_ack) begin
          cap    = 1'b1;
          vld_nx = 1'b1;
          if (i_stall) state_nx = ST_HOLD;
          else         pc_sel   = PC_INC;
        end else begin
          vld_nx = 1'b0;
        end
      end
      ST_KILL: begin
        vld_nx = 1'b0;
        if (i_imem_ack) begin
          // A redirect arriving together with the ack is the newest target.
          pc_sel   = PC_TGT;
          pc_tgt   = redir ? redir_tgt : kill_tgt_q;
          state_nx = ST_REQ;
        end else if (redir) begin
          kill_ld = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redir) begin
          vld_nx   = 1'b0;
          pc_sel   = PC_TGT;
          state_nx = ST_REQ;
        end else if (!i_stall) begin
          vld_nx   = 1'b0;
          pc_sel   = PC_INC;
          state_nx = ST_REQ;
        end
      end
      default: begin
        vld_nx   = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (kill_ld) kill_tgt_q <= redir_tgt;
  end

  // ---- stage p1: registered fetch result to decode ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1     <= 1'b0;
      instr_p1   <= '0;
      pc_p1      <= '0;
      pc_four_p1 <= '0;
    end else begin
      vld_p1 <= vld_nx;
      if (cap) begin
        instr_p1   <= i_imem_rdata;
        pc_p1      <= pc;
        pc_four_p1 <= pc_inc;
      end
    end
  end

  assign o_if_valid = vld_p1;
  assign o_if_instr = instr_p1;
  assign o_if_pc    = pc_p1;
  assign o_pc_four  = pc_four_p1;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer.
// Build with FETCH_TRAP_EN defined to also exercise the trap port.
module tb_fetch_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_br_sel;
  logic [31:0] i_pc_bru;
`ifdef FETCH_TRAP_EN
  logic        i_trap;
`endif
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic [31:0] o_pc_four;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  fetch_sequencer dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_stall      (i_stall),
    .i_br_sel     (i_br_sel),
    .i_pc_bru     (i_pc_bru),
`ifdef FETCH_TRAP_EN
    .i_trap       (i_trap),
`endif
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .o_if_valid   (o_if_valid),
    .o_if_instr   (o_if_instr),
    .o_if_pc      (o_if_pc),
    .o_pc_four    (o_pc_four)
  );

  // Instruction word returned by the memory model for a given address.
  function automatic logic [31:0] insn(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, "_req"}, {31'd0, o_imem_req}, {31'd0, req});
    chk({tag, "_addr"}, o_imem_addr, addr);
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] pc);
    chk({tag, "_vld"}, {31'd0, o_if_valid}, {31'd0, vld});
    if (vld) begin
      chk({tag, "_pc"}, o_if_pc, pc);
      chk({tag, "_instr"}, o_if_instr, insn(pc));
      chk({tag, "_four"}, o_pc_four, pc + 32'd4);
    end
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_stall      = 1'b0;
    i_br_sel     = 1'b0;
    i_pc_bru     = 32'h0;
`ifdef FETCH_TRAP_EN
    i_trap       = 1'b0;
`endif
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'hDEAD_BEEF;

    // Reset with ack asserted: must be ignored.
    tick;
    tick;
    chk_req("rst", 1'b0, 32'h0);
    chk("rst_vld", {31'd0, o_if_valid}, 32'd0);
    chk("rst_instr", o_if_instr, 32'h0);
    chk("rst_pc", o_if_pc, 32'h0);
    chk("rst_four", o_pc_four, 32'h0);

    // Release: one IDLE cycle with no request, ack still ignored.
    i_rst_n = 1'b1;
    #1;
    chk_req("idle", 1'b0, 32'h0);
    tick;
    chk_req("req0", 1'b1, 32'h0);
    chk_out("req0", 1'b0, 32'h0);

    // Back-to-back zero-wait fetches.
    i_imem_rdata = insn(32'h0);
    tick;
    chk_req("seq1", 1'b1, 32'h4);
    chk_out("seq1", 1'b1, 32'h0);
    i_imem_rdata = insn(32'h4);
    tick;
    chk_req("seq2", 1'b1, 32'h8);
    chk_out("seq2", 1'b1, 32'h4);

    // Ack delayed three cycles at 0x8.
    i_imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk_req("wait8", 1'b1, 32'h8);
      chk_out("wait8", 1'b0, 32'h0);
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = insn(32'h8);
    tick;
    chk_req("ack8", 1'b1, 32'hC);
    chk_out("ack8", 1'b1, 32'h8);

    // Fetch 0xC with stall: hold for four cycles, then resume at 0x10.
    i_imem_rdata = insn(32'hC);
    i_stall      = 1'b1;
    tick;
    i_imem_ack = 1'b0;
    chk_req("hold0", 1'b0, 32'hC);
    chk_out("hold0", 1'b1, 32'hC);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk_req("hold", 1'b0, 32'hC);
      chk_out("hold", 1'b1, 32'hC);
    end
    i_stall = 1'b0;
    tick;
    chk_req("unstall", 1'b1, 32'h10);
    chk_out("unstall", 1'b0, 32'h0);
    i_imem_ack   = 1'b1;
    i_imem_rdata = insn(32'h10);
    tick;
    chk_req("f10", 1'b1, 32'h14);
    chk_out("f10", 1'b1, 32'h10);

    // Redirect to 0x203 while 0x14 is unacked: kill, then fetch 0x200.
    i_imem_ack = 1'b0;
    i_br_sel   = 1'b1;
    i_pc_bru   = 32'h203;
    tick;
    i_br_sel = 1'b0;
    chk_req("kill0", 1'b1, 32'h14);
    chk_out("kill0", 1'b0, 32'h0);
    tick;
    chk_req("kill1", 1'b1, 32'h14);
    chk_out("kill1", 1'b0, 32'h0);
    i_imem_ack   = 1'b1;
    i_imem_rdata = insn(32'h14);
    tick;
    chk_req("kill_ack", 1'b1, 32'h200);
    chk_out("kill_ack", 1'b0, 32'h0);
    i_imem_rdata = insn(32'h200);
    tick;
    chk_req("f200", 1'b1, 32'h204);
    chk_out("f200", 1'b1, 32'h200);

    // Redirect with ack in the same cycle: rdata discarded.
    i_br_sel     = 1'b1;
    i_pc_bru     = 32'hFFFF_FFFC;
    i_imem_rdata = insn(32'h204);
    tick;
    i_br_sel = 1'b0;
    chk_req("redir_ack", 1'b1, 32'hFFFF_FFFC);
    chk_out("redir_ack", 1'b0, 32'h0);

    // Wrap of pc + 4.
    i_imem_rdata = insn(32'hFFFF_FFFC);
    tick;
    chk_req("wrap", 1'b1, 32'h0);
    chk_out("wrap", 1'b1, 32'hFFFF_FFFC);
    chk("wrap_four", o_pc_four, 32'h0);

    // Redirect in HOLD overrides stall.
    i_imem_rdata = insn(32'h0);
    i_stall      = 1'b1;
    tick;
    chk_out("hold_b", 1'b1, 32'h0);
    i_imem_ack = 1'b0;
    i_br_sel   = 1'b1;
    i_pc_bru   = 32'h40;
    tick;
    i_br_sel = 1'b0;
    i_stall  = 1'b0;
    chk_req("hold_redir", 1'b1, 32'h40);
    chk_out("hold_redir", 1'b0, 32'h0);

    // Newer redirect in KILL overwrites the latched target.
    i_br_sel = 1'b1;
    i_pc_bru = 32'h80;
    tick;
    i_pc_bru = 32'h91;
    tick;
    i_br_sel = 1'b0;
    chk_req("kill_b", 1'b1, 32'h40);
    i_imem_ack = 1'b1;
    tick;
    chk_req("kill_new", 1'b1, 32'h90);
    chk_out("kill_new", 1'b0, 32'h0);

`ifdef FETCH_TRAP_EN
    // Trap and branch together: trap wins.
    i_trap   = 1'b1;
    i_br_sel = 1'b1;
    i_pc_bru = 32'h400;
    tick;
    i_trap   = 1'b0;
    i_br_sel = 1'b0;
    chk_req("trap", 1'b1, 32'h100);
    chk_out("trap", 1'b0, 32'h0);
`endif

    // Reset mid-request abandons it immediately.
    i_imem_ack   = 1'b0;
    i_imem_rdata = insn(o_imem_addr);
    tick;
    i_rst_n = 1'b0;
    #1;
    chk_req("midrst", 1'b0, 32'h0);
    chk_out("midrst", 1'b0, 32'h0);
    i_imem_ack = 1'b1;
    tick;
    chk_req("midrst_ack", 1'b0, 32'h0);
    i_rst_n = 1'b1;
    i_imem_rdata = insn(32'h0);
    tick;
    chk_req("rerun", 1'b1, 32'h0);
    chk_out("rerun", 1'b0, 32'h0);
    tick;
    chk_req("rerun1", 1'b1, 32'h4);
    chk_out("rerun1", 1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000: first fetch address after reset SHALL be this value.
REQ-002 Parameter TRAP_VECTOR, 32'h0000_0100: trap redirect target, used only under FETCH_TRAP_EN.
REQ-003 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_stall  in  1  hazard hold from decode; freezes delivered instruction.
REQ-006 i_br_sel  in  1  redirect request from branch unit.
REQ-007 i_pc_bru  in  32  redirect target; bits [1:0] SHALL be ignored and treated as 0.
REQ-008 o_imem_req  out  1  instruction memory request.
REQ-009 o_imem_addr  out  32  request address, word aligned.
REQ-010 i_imem_ack  in  1  one-cycle acknowledge; i_imem_rdata is valid in the same cycle.
REQ-011 i_imem_rdata  in  32  fetched instruction.
REQ-012 o_if_valid, o_if_instr[31:0], o_if_pc[31:0], o_pc_four[31:0]  out  registered fetch result to decode; o_pc_four = o_if_pc + 4.

Function
REQ-013 FSM states SHALL be IDLE, REQ, KILL, HOLD.
REQ-014 IDLE: lasts exactly one cycle after reset release, with o_imem_req=0; then moves to REQ with pc=RESET_VECTOR.
REQ-015 REQ: o_imem_req=1 and o_imem_addr=pc; once asserted, o_imem_req and o_imem_addr SHALL hold unchanged until i_imem_ack.
REQ-016 REQ, ack, no redirect, no stall: next cycle o_if_valid=1 with o_if_instr=i_imem_rdata and o_if_pc=pc; pc<=pc+4; stay in REQ (back-to-back fetch, one instruction per cycle at zero wait states).
REQ-017 REQ, ack, i_stall=1: capture the instruction, then go to HOLD; pc does not advance.
REQ-018 HOLD: o_if_valid and o_if_* held and o_imem_req=0; when i_stall=0, pc<=pc+4, o_if_valid<=0 and go to REQ.
REQ-019 Redirect (i_br_sel=1) in REQ with ack in the same cycle: discard rdata, o_if_valid<=0, pc<=target, stay in REQ.
REQ-020 Redirect in REQ without ack: latch target, go to KILL, o_if_valid<=0.
REQ-021 KILL: keep the outstanding request stable; on ack, discard rdata, pc<=latched target, go to REQ; a newer redirect while in KILL SHALL overwrite the latched target.
REQ-022 Redirect in HOLD or IDLE: o_if_valid<=0, pc<=target, go to REQ; redirect overrides i_stall.
REQ-023 Priority SHALL be trap > redirect > stall > sequential.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-025 o_if_valid SHALL never assert for a fetch whose request preceded an accepted redirect.

Reset
REQ-026 While i_rst_n=0: state=IDLE, pc=RESET_VECTOR, o_imem_req=0, o_if_valid=0, o_if_instr=0, o_if_pc=0, o_pc_four=0; o_imem_addr=RESET_VECTOR.
REQ-027 Reset mid-request SHALL abandon the request immediately; an ack arriving during reset or IDLE SHALL be ignored.

Configuration
REQ-028 Macro FETCH_TRAP_EN defined: add port i_trap (in, 1); i_trap=1 acts as a redirect to TRAP_VECTOR under REQ-019..022, with top priority.
REQ-029 FETCH_TRAP_EN undefined: i_trap is absent, TRAP_VECTOR is unused, and behaviour is otherwise identical.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the FSM state enum, INSN_BYTES=4 and the default RESET_VECTOR/TRAP_VECTOR constants.
REQ-031 One sub-module, fetch_pc_reg, SHALL hold the pc register, the next-pc mux (target/pc+4/hold) and the +4 adder; the FSM drives its selects.

Verification
REQ-032 Reset release, ack every cycle -> o_imem_addr 0x0,0x4,0x8; o_if_valid from cycle 2 with matching o_if_pc.
REQ-033 Ack delayed 3 cycles at 0x8 -> o_imem_req/o_imem_addr=0x8 held stable for 3 cycles; single valid for 0x8.
REQ-034 i_stall=1 for 4 cycles after fetching 0xC -> o_if_* held with o_if_pc=0xC, no request; the next request after release is 0x10.
REQ-035 i_br_sel with i_pc_bru=0x203 while a request to 0x14 is unacked -> KILL; 0x14 rdata discarded; next request is 0x200; no valid for 0x14.
REQ-036 pc=0xFFFF_FFFC acked -> next request 0x0, o_pc_four=0x0.
REQ-037 FETCH_TRAP_EN: i_trap and i_br_sel (0x400) asserted together -> next request 0x100.
